regfile_arbiter: RTL

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 19 +
 rtl/regfile_arbiter_if.sv | 38 +++
 rtl/regfile_arbiter_rr_arb2.sv | 33 +++
 rtl/regfile_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared types and constants for the regfile arbiter
// Contents: FSM state enum, default data/address widths, requester index constants.

package regfile_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Requester indices as carried in the latched winner / priority pointer.
  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester and regfile bus bundle for the regfile arbiter
// Requester side: req/we/addr/wdata in, gnt/rvalid/rdata out (one set per requester).
// Regfile side:   rf_selin/rf_selout/rf_inp/rf_read/rf_write/rf_en out, rf_out in.
// Modports: slave = arbiter, master = requesters plus regfile.

interface regfile_arbiter_if
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic [ADDR_W-1:0] rf_selin, rf_selout;
  logic [DATA_W-1:0] rf_inp;
  logic              rf_read, rf_write, rf_en;
  logic [DATA_W-1:0] rf_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output rf_selin, rf_selout, rf_inp, rf_read, rf_write, rf_en
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  rf_selin, rf_selout, rf_inp, rf_read, rf_write, rf_en
  );

endinterface

// File: rtl/regfile_arbiter_rr_arb2.sv
// rtl/regfile_arbiter_rr_arb2.sv - two-way round-robin selector (module rr_arb2)
// Ports: clk, reset (async, active-high); req[1:0] requests; advance = a grant is
// taken this cycle; win = winning requester index; any = at least one request.

module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       win,
  output logic       any
);

  logic ptr;

  // The pointer only matters on contention; a lone requester always wins.
  always_comb begin
    any = |req;
    win = (req[0] & req[1]) ? ptr : req[1];
  end

  // After every grant the other requester gets priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ_IDX0;
    end else if (advance) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin arbiter in front of a single-port regfile
// Ports: clk, reset (async, active-high), bus (regfile_arbiter_if.slave) carrying both
// requester handshakes and the regfile select/data/strobe lines.

module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  regfile_arbiter_if.slave   bus
);

  state_t            state, state_nx;
  logic              win, any, grant_take;
  logic              win_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic              rf_read, rf_write, rf_en;
  logic [ADDR_W-1:0] rf_selin, rf_selout;
  logic [DATA_W-1:0] rf_inp;

  // Requests are only looked at in IDLE, so the pointer moves once per transfer.
  assign grant_take = (state == IDLE) && any;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.req1, bus.req0}),
    .advance (grant_take),
    .win     (win),
    .any     (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      win_q    <= REQ_IDX0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nx;
      if (grant_take) begin
        win_q   <= win;
        we_q    <= win ? bus.we1    : bus.we0;
        addr_q  <= win ? bus.addr1  : bus.addr0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state == RDWAIT) begin
        if (win_q == REQ_IDX1) begin
          rdata1_q <= bus.rf_out;
        end else begin
          rdata0_q <= bus.rf_out;
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rf_en     = 1'b0;
    rf_read   = 1'b0;
    rf_write  = 1'b0;
    rf_selin  = '0;
    rf_selout = '0;
    rf_inp    = '0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        rf_en = 1'b1;
        gnt0  = (win_q == REQ_IDX0);
        gnt1  = (win_q == REQ_IDX1);
        if (we_q) begin
          rf_write = 1'b1;
          rf_selin = addr_q;
          rf_inp   = wdata_q;
          state_nx = IDLE;
        end else begin
          rf_read   = 1'b1;
          rf_selout = addr_q;
          state_nx  = RDWAIT;
        end
      end
      RDWAIT: begin
        rvalid0  = (win_q == REQ_IDX0);
        rvalid1  = (win_q == REQ_IDX1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.rf_en     = rf_en;
  assign bus.rf_read   = rf_read;
  assign bus.rf_write  = rf_write;
  assign bus.rf_selin  = rf_selin;
  assign bus.rf_selout = rf_selout;
  assign bus.rf_inp    = rf_inp;

  // rf_out is already valid during RDWAIT, so it is forwarded while rvalid is high
  // and the captured copy is held afterwards.
  assign bus.rdata0 = rvalid0 ? bus.rf_out : rdata0_q;
  assign bus.rdata1 = rvalid1 ? bus.rf_out : rdata1_q;

endmodule
